// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- transmit-side UART serializer
//
// Pops 9-bit words from a first-word-fall-through FIFO and shifts them onto the
// serial line, advancing one bit-time per baud tick. Word bit 8 requests a line
// break (line held low for BREAK_BITS bit-times) instead of a data frame.
//
// Parameters
//   PARITY_EN   1 = append a parity bit after the 8 data bits
//   PARITY_ODD  1 = odd parity, 0 = even (ignored when PARITY_EN = 0)
//   STOP_BITS   stop bits per frame, 1 or 2
//   BREAK_BITS  bit-times the line stays low for a break word, 1..255
//
// Ports
//   CLK288MHZ    in   clock
//   reset        in   synchronous, active-high
//   tick         in   one-cycle baud strobe (1x bit rate)
//   fifoDataIn   in   [8] break request, [7:0] payload; valid while !fifoEmpty
//   fifoEmpty    in   FIFO empty flag
//   fifoReadEn   out  pop strobe, combinational; the word is latched on that edge
//   uart_txd_in  out  serial line, idle high, registered
//   busy         out  high while a frame or break is on the line, registered
//   txDone       out  one-cycle pulse after the tick that ends the last stop bit
// -----------------------------------------------------------------------------
module uart_tx #(
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1,
   parameter int BREAK_BITS = 12
) (
   input  logic       CLK288MHZ,
   input  logic       reset,
   input  logic       tick,
   input  logic [8:0] fifoDataIn,
   input  logic       fifoEmpty,
   output logic       fifoReadEn,
   output logic       uart_txd_in,
   output logic       busy,
   output logic       txDone
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_BREAK,
      S_STOP
   } state_t;

   localparam logic       PAR_EN     = (PARITY_EN != 0);
   localparam logic       PAR_ODD    = (PARITY_ODD != 0);
   // Only 1 or 2 stop bits exist, so a single-bit counter suffices.
   localparam logic       STOP_LAST  = (STOP_BITS == 2);
   localparam logic [7:0] BREAK_LAST = 8'(BREAK_BITS - 1);

   state_t     state_q;
   logic [7:0] data_q;
   logic [2:0] bit_idx_q;
   logic [7:0] brk_cnt_q;
   logic       stop_cnt_q;
   logic       txd_q;
   logic       busy_q;
   logic       done_q;

   logic       last_stop_d;
   logic       load_d;

   // A new word may be taken from idle, or on the tick that closes the final
   // stop bit so consecutive frames run with no idle gap between them.
   assign last_stop_d = (state_q == S_STOP) && (stop_cnt_q == STOP_LAST);
   assign load_d      = tick && !fifoEmpty && !reset &&
                        ((state_q == S_IDLE) || last_stop_d);

   assign fifoReadEn  = load_d;
   assign uart_txd_in = txd_q;
   assign busy        = busy_q;
   assign txDone      = done_q;

   always_ff @(posedge CLK288MHZ) begin
      if (reset) begin
         state_q    <= S_IDLE;
         data_q     <= 8'd0;
         bit_idx_q  <= 3'd0;
         brk_cnt_q  <= 8'd0;
         stop_cnt_q <= 1'b0;
         txd_q      <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (tick) begin
            // txd_q always carries the level of the bit-time that begins on
            // this tick, so the line lags the state by exactly one cycle.
            case (state_q)
               S_IDLE: begin
                  txd_q <= 1'b1;
               end
               S_START: begin
                  txd_q     <= data_q[0];
                  bit_idx_q <= 3'd0;
                  state_q   <= S_DATA;
               end
               S_DATA: begin
                  if (bit_idx_q == 3'd7) begin
                     if (PAR_EN) begin
                        txd_q   <= (^data_q) ^ PAR_ODD;
                        state_q <= S_PARITY;
                     end else begin
                        txd_q      <= 1'b1;
                        stop_cnt_q <= 1'b0;
                        state_q    <= S_STOP;
                     end
                  end else begin
                     txd_q     <= data_q[bit_idx_q + 3'd1];
                     bit_idx_q <= bit_idx_q + 3'd1;
                  end
               end
               S_PARITY: begin
                  txd_q      <= 1'b1;
                  stop_cnt_q <= 1'b0;
                  state_q    <= S_STOP;
               end
               S_BREAK: begin
                  if (brk_cnt_q == BREAK_LAST) begin
                     txd_q      <= 1'b1;
                     stop_cnt_q <= 1'b0;
                     state_q    <= S_STOP;
                  end else begin
                     brk_cnt_q <= brk_cnt_q + 8'd1;
                  end
               end
               S_STOP: begin
                  if (last_stop_d) begin
                     done_q  <= 1'b1;
                     txd_q   <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= S_IDLE;
                  end else begin
                     stop_cnt_q <= 1'b1;
                  end
               end
               default: begin
                  txd_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            endcase

            // A pop overrides the idle/stop decisions above: the start (or
            // break) bit begins on this same tick.
            if (load_d) begin
               data_q     <= fifoDataIn[7:0];
               bit_idx_q  <= 3'd0;
               brk_cnt_q  <= 8'd0;
               stop_cnt_q <= 1'b0;
               txd_q      <= 1'b0;
               busy_q     <= 1'b1;
               state_q    <= fifoDataIn[8] ? S_BREAK : S_START;
            end
         end
      end
   end

endmodule
